// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOP encodings,
// default latencies and the FSM state type.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } mdop_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 8;

    // True for the opcodes that launch a multi-cycle operation.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == 3'(MD_DIV)) || (op == 3'(MD_DIVU));
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Operand/control bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOP;
    logic        Start;
    logic        HLsel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    modport master (
        output A, B, MDOP, Start, HLsel,
        input  Busy, HI, LO, Out
    );

    modport slave (
        input  A, B, MDOP, Start, HLsel,
        output Busy, HI, LO, Out
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit mult/div result: {HI, LO}. Division yields
// {remainder, quotient}; a zero divisor is flagged instead of computed.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    output logic [63:0] res_o,
    output logic        div_by_zero_o
);

    logic signed [63:0] sa_ext;
    logic signed [63:0] sb_ext;

    assign sa_ext = $signed({{32{a_i[31]}}, a_i});
    assign sb_ext = $signed({{32{b_i[31]}}, b_i});

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        res_o         = '0;
        div_by_zero_o = 1'b0;
        case (mdop_e'(op_i))
            MD_MULT:  res_o = sa_ext * sb_ext;
            MD_MULTU: res_o = {32'h0, a_i} * {32'h0, b_i};
            MD_DIV: begin
                if (b_i == 32'h0) begin
                    div_by_zero_o = 1'b1;
                end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    // The only signed overflow: quotient wraps to itself, remainder is zero.
                    res_o = {32'h0, 32'h8000_0000};
                end else begin
                    res_o = {32'($signed(a_i) % $signed(b_i)),
                             32'($signed(a_i) / $signed(b_i))};
                end
            end
            MD_DIVU: begin
                if (b_i == 32'h0) begin
                    div_by_zero_o = 1'b1;
                end else begin
                    res_o = {a_i % b_i, a_i / b_i};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, sequences mult/div latency with a
// down-counter and presents HI or LO to the EX result mux.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              dz_q, dz_d;
    logic [31:0]       tmp_hi_q, tmp_hi_d;
    logic [31:0]       tmp_lo_q, tmp_lo_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic [63:0]       res;
    logic              div_by_zero;

    mdu_arith u_arith (
        .a_i           (bus.A),
        .b_i           (bus.B),
        .op_i          (bus.MDOP),
        .res_o         (res),
        .div_by_zero_o (div_by_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        dz_d     = dz_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.Start && is_md_op(bus.MDOP)) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = is_div_op(bus.MDOP) ? DIV_N : MULT_N;
                    dz_d     = div_by_zero;
                    tmp_hi_d = res[63:32];
                    tmp_lo_d = res[31:0];
                end else if (bus.MDOP == 3'(MD_MTHI)) begin
                    hi_d = bus.A;
                end else if (bus.MDOP == 3'(MD_MTLO)) begin
                    lo_d = bus.A;
                end
            end
            RUN: begin
                // Start and mthi/mtlo are deliberately ignored while running.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            dz_q     <= dz_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.Out  = bus.HLsel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO results are queued at launch
// and compared when Busy falls; a shadow HI/LO tracks the visible registers.
module tb_mdu;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mdu_if bus();

    mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    // Present one operation for exactly one rising edge; returns 1ns after it.
    task automatic drive_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic start);
        @(negedge clk);
        bus.MDOP  = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = start;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.MDOP  = 3'(MD_NONE);
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        sb_q.push_back('{hi: exp_hi, lo: exp_lo});
        drive_op(op, a, b, 1'b1);
    endtask

    // Called 1ns after the launch edge k; the result must land exactly at edge k+n.
    task automatic await_result(input string name, input int n);
        exp_t e;
        tests_run++;
        if (bus.Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_at_launch: got %b want 1", name, bus.Busy);
        end
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.Busy !== 1'b1 || bus.HI !== hi_m || bus.LO !== lo_m) begin
                tests_failed++;
                $display("FAIL %s running cycle %0d: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                         name, i, bus.Busy, bus.HI, bus.LO, hi_m, lo_m);
            end
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: empty when result expected", name);
            return;
        end
        e = sb_q.pop_front();
        if (bus.Busy !== 1'b0 || bus.HI !== e.hi || bus.LO !== e.lo) begin
            tests_failed++;
            $display("FAIL %s done: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     name, bus.Busy, bus.HI, bus.LO, e.hi, e.lo);
        end
        hi_m = e.hi;
        lo_m = e.lo;
        bus.HLsel = 1'b1;
        #1;
        tests_run++;
        if (bus.Out !== hi_m) begin
            tests_failed++;
            $display("FAIL %s out_hi: got %h want %h", name, bus.Out, hi_m);
        end
        bus.HLsel = 1'b0;
        #1;
        tests_run++;
        if (bus.Out !== lo_m) begin
            tests_failed++;
            $display("FAIL %s out_lo: got %h want %h", name, bus.Out, lo_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                @(negedge clk);
                reset = 1'b1;
                repeat (3) @(posedge clk);
                #1;
            end
            tests_run++;
            if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset pass%0d: busy=%b hi=%h lo=%h want 0/0/0",
                         pass, bus.Busy, bus.HI, bus.LO);
            end
            bus.HLsel = 1'b1;
            #1;
            tests_run++;
            if (bus.Out !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset out_hi pass%0d: got %h want 0", pass, bus.Out);
            end
            bus.HLsel = 1'b0;
            #1;
            tests_run++;
            if (bus.Out !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset out_lo pass%0d: got %h want 0", pass, bus.Out);
            end
        end
    endtask

    task automatic test_mult();
        launch(3'(MD_MULT), 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        await_result("mult", 5);
        launch(3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        await_result("multu", 5);
    endtask

    task automatic test_div();
        launch(3'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        await_result("div_neg", 10);
        launch(3'(MD_DIVU), 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        await_result("divu", 10);
        launch(3'(MD_DIV), 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        await_result("div_neg_divisor", 10);
        launch(3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        await_result("div_overflow", 10);
    endtask

    task automatic test_mthi_mtlo();
        drive_op(3'(MD_MTHI), 32'h1234_5678, 32'h0, 1'b0);
        hi_m = 32'h1234_5678;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.HI !== hi_m || bus.LO !== lo_m) begin
            tests_failed++;
            $display("FAIL mthi: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     bus.Busy, bus.HI, bus.LO, hi_m, lo_m);
        end
        // Start alongside mtlo must be ignored while the write still happens.
        drive_op(3'(MD_MTLO), 32'h9ABC_DEF0, 32'h0, 1'b1);
        lo_m = 32'h9ABC_DEF0;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.HI !== hi_m || bus.LO !== lo_m) begin
            tests_failed++;
            $display("FAIL mtlo: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     bus.Busy, bus.HI, bus.LO, hi_m, lo_m);
        end
        drive_op(3'(MD_MULT), 32'd5, 32'd5, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.HI !== hi_m || bus.LO !== lo_m) begin
            tests_failed++;
            $display("FAIL mult_no_start: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     bus.Busy, bus.HI, bus.LO, hi_m, lo_m);
        end
        launch(3'(MD_DIV), 32'h0000_0055, 32'h0, hi_m, lo_m);
        await_result("div_by_zero", 10);
        launch(3'(MD_DIVU), 32'hFFFF_FFFF, 32'h0, hi_m, lo_m);
        await_result("divu_by_zero", 10);
    endtask

    task automatic test_ignore_while_busy();
        exp_t e;
        launch(3'(MD_DIVU), 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                bus.MDOP  = 3'(MD_MULT);
                bus.A     = 32'd7;
                bus.B     = 32'd9;
                bus.Start = 1'b1;
            end else if (cyc == 4) begin
                bus.MDOP  = 3'(MD_MTHI);
                bus.A     = 32'hDEAD_BEEF;
                bus.Start = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.Start = 1'b0;
            bus.MDOP  = 3'(MD_NONE);
            tests_run++;
            if (cyc < 10) begin
                if (bus.Busy !== 1'b1 || bus.HI !== hi_m || bus.LO !== lo_m) begin
                    tests_failed++;
                    $display("FAIL ignore cycle %0d: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                             cyc, bus.Busy, bus.HI, bus.LO, hi_m, lo_m);
                end
            end else if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ignore scoreboard: empty when result expected");
            end else begin
                e = sb_q.pop_front();
                if (bus.Busy !== 1'b0 || bus.HI !== e.hi || bus.LO !== e.lo) begin
                    tests_failed++;
                    $display("FAIL ignore done: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                             bus.Busy, bus.HI, bus.LO, e.hi, e.lo);
                end
                hi_m = e.hi;
                lo_m = e.lo;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.HI !== hi_m || bus.LO !== lo_m) begin
            tests_failed++;
            $display("FAIL ignore aftermath: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     bus.Busy, bus.HI, bus.LO, hi_m, lo_m);
        end
    endtask

    task automatic test_reset_mid_op();
        drive_op(3'(MD_MULT), 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        hi_m = 32'h0;
        lo_m = 32'h0;
        tests_run++;
        if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_op immediate: busy=%b hi=%h lo=%h want 0/0/0",
                     bus.Busy, bus.HI, bus.LO);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_mid_op stale cycle %0d: busy=%b hi=%h lo=%h want 0/0/0",
                         i, bus.Busy, bus.HI, bus.LO);
            end
        end
    endtask

    initial begin
        bus.A     = 32'h0;
        bus.B     = 32'h0;
        bus.MDOP  = 3'(MD_NONE);
        bus.Start = 1'b0;
        bus.HLsel = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage, beside the ALU. Fed by the same forwarded rs/rt operands.
- Holds the architectural HI/LO registers and runs MIPS mult/multu/div/divu as multi-cycle operations.
- Handles mthi/mtlo writes and supplies HI or LO to the EX result mux for mfhi/mflo.
- Drives Busy so the stall controller holds multiply/divide-family instructions in ID.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO update for mult/multu.
- DIV_CYCLES, 10, cycles from start to HI/LO update for div/divu.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- A  input  32  forwarded rs operand
- B  input  32  forwarded rt operand
- MDOP  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- Start  input  1  single-cycle pulse; valid only with MDOP 1-4
- HLsel  input  1  Out select: 0 LO, 1 HI
- Busy  output  1  multi-cycle operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- Out  output  32  HLsel ? HI : LO, combinational

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0, state IDLE. Out follows HLsel, so it reads 0.
- States: IDLE and RUN.
- IDLE to RUN: at a rising edge where Start=1 and MDOP is 1-4.
  - The full 64-bit result is computed from A/B at that edge and captured in internal temp_hi/temp_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from that edge onward.
- RUN: counter decrements each edge. At the edge where the counter reaches 1:
  - HI<=temp_hi, LO<=temp_lo.
  - Busy<=0, return to IDLE.
  - With Start sampled at edge k, HI/LO change and Busy falls at edge k+N, where N = MULT_CYCLES or DIV_CYCLES.
- Arithmetic:
  - mult: signed 32x32 to 64. multu: unsigned. HI=upper 32 bits, LO=lower 32 bits.
  - div: signed. LO=quotient, HI=remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): the operation still occupies DIV_CYCLES with Busy=1, but HI/LO stay unchanged at completion.
- mthi/mtlo (MDOP 5/6, Start=0): HI<=A or LO<=A at the edge, single cycle, Busy stays 0.
- Simultaneous or illegal events:
  - Start while Busy=1: ignored; the in-flight operation completes unchanged. The stall controller guarantees this never happens.
  - mthi/mtlo while Busy=1: ignored.
  - Start with MDOP 0, 5, 6 or 7: Start is ignored. MDOP 5/6 still perform their write.
  - MDOP 1-4 without Start: no effect.
- Out is purely combinational from the HI/LO registers. During RUN it shows the pre-operation values.
- Reset asserted mid-operation: immediately IDLE, Busy=0, HI=LO=0. The pending result is discarded.
- Stall rule for the controller (documented here, implemented in the controller): stall any MD-family instruction in ID while (Start | Busy).

Decomposition:
- Shared package mdu_pkg:
  - MDOP encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default cycle counts.
  - Two-state enum: IDLE, RUN.
- Sub-module mdu_arith: combinational 64-bit result computation from A, B and MDOP, including divide-by-zero detection.
- mdu keeps the FSM, counter, temp registers, HI/LO and the Out mux.

Test Plan:
- Reset held low, then released with no operations: HI=LO=0, Busy=0, Out=0.
- mult with A=0xFFFFFFFD (-3), B=5, Start at edge k:
  - Busy=1 for edges k through k+4.
  - At edge k+5: HI=0xFFFFFFFF, LO=0xFFFFFFF1, Busy=0.
  - multu with A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with the same operands: LO=0x7FFFFFFC, HI=0x00000001.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0: each updates in one cycle with Busy=0.
  - Then div with B=0: Busy high for 10 cycles; HI/LO remain 0x12345678 / 0x9ABCDEF0.
- Start a divu, assert Start again with mult at cycle 3, then mthi at cycle 4:
  - Both are ignored.
  - At cycle 10 the divu result lands; Busy falls.
- Start a mult, pull reset low at cycle 2: Busy=0 and HI=LO=0 immediately. After release, no stale result appears.
